// File: rtl/tnoc_injector_pkg.sv
// -----------------------------------------------------------------------------
// tnoc_injector_pkg
//   Shared types and helpers for the local-port flit injector.
//   - tnoc_config_t / TNOC_DEFAULT_CONFIG : fabric configuration (VC count and
//     node-coordinate widths).
//   - tnoc_injector_state_e               : injector FSM encoding.
//   - tnoc_head_fields_t                  : head-flit fields, each zero-extended
//     to FIELD_WIDTH before being packed into the flit data word.
//   - calc_len_width / calc_vc_width      : derived field widths.
// -----------------------------------------------------------------------------
package tnoc_injector_pkg;

    typedef struct packed {
        int virtual_channels;
        int id_x_width;
        int id_y_width;
    } tnoc_config_t;

    localparam tnoc_config_t TNOC_DEFAULT_CONFIG = '{
        virtual_channels: 2,
        id_x_width:       4,
        id_y_width:       4
    };

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEAD    = 2'd1,
        PAYLOAD = 2'd2
    } tnoc_injector_state_e;

    // Upper bound on any single head field; coordinate, VC and length widths
    // must not exceed it.
    localparam int FIELD_WIDTH = 16;

    typedef struct packed {
        logic [FIELD_WIDTH-1:0] dest_y;
        logic [FIELD_WIDTH-1:0] dest_x;
        logic [FIELD_WIDTH-1:0] src_y;
        logic [FIELD_WIDTH-1:0] src_x;
        logic [FIELD_WIDTH-1:0] vc;
        logic [FIELD_WIDTH-1:0] length;
    } tnoc_head_fields_t;

    // Width of a beat count able to hold 0..max_payload.
    function automatic int calc_len_width(input int max_payload);
        return $clog2(max_payload + 1);
    endfunction

    function automatic int calc_vc_width(input int vcs);
        return (vcs > 1) ? $clog2(vcs) : 1;
    endfunction

endpackage

// File: rtl/tnoc_flit_out_reg.sv
// -----------------------------------------------------------------------------
// tnoc_flit_out_reg
//   Single-entry valid/ready output register with one-hot VC steering.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     push            : load a new flit (only when can_accept=1)
//     push_vc/head/tail/data : flit to load
//     can_accept      : register empty or draining this cycle
//     flit_ready      : per-VC ready from the fabric
//     flit_valid      : one-hot per-VC valid (bit vc_q only)
//     flit_head/tail/data : registered flit contents
// -----------------------------------------------------------------------------
module tnoc_flit_out_reg
    import tnoc_injector_pkg::*;
#(
    parameter int  CHANNELS   = 2,
    parameter int  DATA_WIDTH = 64,
    localparam int VC_WIDTH   = calc_vc_width(CHANNELS)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [VC_WIDTH-1:0]   push_vc,
    input  logic                  push_head,
    input  logic                  push_tail,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  can_accept,
    input  logic [CHANNELS-1:0]   flit_ready,
    output logic [CHANNELS-1:0]   flit_valid,
    output logic                  flit_head,
    output logic                  flit_tail,
    output logic [DATA_WIDTH-1:0] flit_data
);

    logic                valid_q;
    logic [VC_WIDTH-1:0] vc_q;
    logic                drain;

    assign drain      = valid_q & flit_ready[vc_q];
    // Refill in the same cycle the entry drains keeps one flit per cycle.
    assign can_accept = ~valid_q | drain;
    assign flit_valid = valid_q ? (CHANNELS'(1) << vc_q) : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the data register is reset too because its contents
    // are visible on the port and must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            vc_q      <= '0;
            flit_head <= 1'b0;
            flit_tail <= 1'b0;
            flit_data <= '0;
        end else if (push) begin
            valid_q   <= 1'b1;
            vc_q      <= push_vc;
            flit_head <= push_head;
            flit_tail <= push_tail;
            flit_data <= push_data;
        end else if (drain) begin
            valid_q   <= 1'b0;
        end
    end

endmodule

// File: rtl/tnoc_flit_injector.sv
// -----------------------------------------------------------------------------
// tnoc_flit_injector
//   Serializes a packet descriptor plus payload beats into one head flit and
//   N body flits on a single VC, one packet at a time (wormhole order).
//   Ports:
//     clk, rst_n                       : clock, asynchronous active-low reset
//     i_id_x, i_id_y                   : static source coordinates
//     i_hdr_valid/o_hdr_ready          : descriptor handshake
//     i_hdr_vc, i_hdr_dest_x/y, i_hdr_length : descriptor fields
//     i_pld_valid/o_pld_ready          : payload handshake
//     i_pld_data, i_pld_last           : payload beat and client end marker
//     o_flit_valid/i_flit_ready        : per-VC flit handshake to the fabric
//     o_flit_head, o_flit_tail, o_flit_data : flit contents
//     o_error                          : sticky length/last mismatch
// -----------------------------------------------------------------------------
module tnoc_flit_injector
    import tnoc_injector_pkg::*;
#(
    parameter tnoc_config_t CONFIG      = TNOC_DEFAULT_CONFIG,
    parameter int           DATA_WIDTH  = 64,
    parameter int           MAX_PAYLOAD = 16,
    localparam int          CHANNELS    = CONFIG.virtual_channels,
    localparam int          ID_X_WIDTH  = CONFIG.id_x_width,
    localparam int          ID_Y_WIDTH  = CONFIG.id_y_width,
    localparam int          VC_WIDTH    = calc_vc_width(CHANNELS),
    localparam int          LEN_WIDTH   = calc_len_width(MAX_PAYLOAD)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_X_WIDTH-1:0] i_id_x,
    input  logic [ID_Y_WIDTH-1:0] i_id_y,
    input  logic                  i_hdr_valid,
    output logic                  o_hdr_ready,
    input  logic [VC_WIDTH-1:0]   i_hdr_vc,
    input  logic [ID_X_WIDTH-1:0] i_hdr_dest_x,
    input  logic [ID_Y_WIDTH-1:0] i_hdr_dest_y,
    input  logic [LEN_WIDTH-1:0]  i_hdr_length,
    input  logic                  i_pld_valid,
    output logic                  o_pld_ready,
    input  logic [DATA_WIDTH-1:0] i_pld_data,
    input  logic                  i_pld_last,
    output logic [CHANNELS-1:0]   o_flit_valid,
    input  logic [CHANNELS-1:0]   i_flit_ready,
    output logic                  o_flit_head,
    output logic                  o_flit_tail,
    output logic [DATA_WIDTH-1:0] o_flit_data,
    output logic                  o_error
);

    tnoc_injector_state_e state_q, state_d;
    logic [VC_WIDTH-1:0]  vc_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [LEN_WIDTH-1:0] cnt_q;
    logic [LEN_WIDTH-1:0] cnt_next;
    logic                 init_q;
    logic                 error_q;

    logic                 can_accept;
    logic                 hdr_fire;
    logic                 pld_fire;
    logic                 beat_is_tail;
    logic                 hdr_len_over;
    logic [LEN_WIDTH-1:0] hdr_len;

    logic                  push;
    logic [VC_WIDTH-1:0]   push_vc;
    logic                  push_head;
    logic                  push_tail;
    logic [DATA_WIDTH-1:0] push_data;

    tnoc_head_fields_t     head_fields;
    logic [DATA_WIDTH-1:0] head_data;

    // Over-long descriptors are clamped; the error flag records it.
    assign hdr_len_over = (i_hdr_length > LEN_WIDTH'(MAX_PAYLOAD));
    assign hdr_len      = hdr_len_over ? LEN_WIDTH'(MAX_PAYLOAD) : i_hdr_length;

    // init_q keeps o_hdr_ready low while reset is asserted.
    assign o_hdr_ready = (state_q == IDLE)    & init_q & can_accept;
    assign o_pld_ready = (state_q == PAYLOAD) & can_accept;
    assign hdr_fire    = i_hdr_valid & o_hdr_ready;
    assign pld_fire    = i_pld_valid & o_pld_ready;

    // The beat counter, not i_pld_last, decides where the packet ends.
    assign cnt_next     = cnt_q + LEN_WIDTH'(1);
    assign beat_is_tail = (cnt_next == len_q);
    assign o_error      = error_q;

    assign head_fields.dest_y = FIELD_WIDTH'(i_hdr_dest_y);
    assign head_fields.dest_x = FIELD_WIDTH'(i_hdr_dest_x);
    assign head_fields.src_y  = FIELD_WIDTH'(i_id_y);
    assign head_fields.src_x  = FIELD_WIDTH'(i_id_x);
    assign head_fields.vc     = FIELD_WIDTH'(i_hdr_vc);
    assign head_fields.length = FIELD_WIDTH'(hdr_len);

    // LSB-packed {dest_y, dest_x, src_y, src_x, vc, length}, zero-extended.
    assign head_data =
          DATA_WIDTH'(head_fields.length)
        | (DATA_WIDTH'(head_fields.vc)     << LEN_WIDTH)
        | (DATA_WIDTH'(head_fields.src_x)  << (LEN_WIDTH + VC_WIDTH))
        | (DATA_WIDTH'(head_fields.src_y)  << (LEN_WIDTH + VC_WIDTH + ID_X_WIDTH))
        | (DATA_WIDTH'(head_fields.dest_x) << (LEN_WIDTH + VC_WIDTH + ID_X_WIDTH + ID_Y_WIDTH))
        | (DATA_WIDTH'(head_fields.dest_y) << (LEN_WIDTH + VC_WIDTH + 2*ID_X_WIDTH + ID_Y_WIDTH));

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_vc   = vc_q;
        push_head = 1'b0;
        push_tail = 1'b0;
        push_data = '0;
        case (state_q)
            IDLE: begin
                if (hdr_fire) begin
                    push      = 1'b1;
                    push_vc   = i_hdr_vc;
                    push_head = 1'b1;
                    push_tail = (hdr_len == '0);
                    push_data = head_data;
                    state_d   = (hdr_len == '0) ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (pld_fire) begin
                    push      = 1'b1;
                    push_tail = beat_is_tail;
                    push_data = i_pld_data;
                    if (beat_is_tail) begin
                        state_d = IDLE;
                    end
                end
            end
            // HEAD is never entered: the head flit lives in the output
            // register while the FSM already sits in IDLE or PAYLOAD.
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            init_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            init_q  <= 1'b1;
            state_q <= state_d;
            if (hdr_fire) begin
                vc_q  <= i_hdr_vc;
                len_q <= hdr_len;
                cnt_q <= '0;
                if (hdr_len_over) begin
                    error_q <= 1'b1;
                end
            end
            if (pld_fire) begin
                cnt_q <= beat_is_tail ? '0 : cnt_next;
                if (i_pld_last != beat_is_tail) begin
                    error_q <= 1'b1;
                end
            end
        end
    end

    tnoc_flit_out_reg #(
        .CHANNELS   (CHANNELS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_vc    (push_vc),
        .push_head  (push_head),
        .push_tail  (push_tail),
        .push_data  (push_data),
        .can_accept (can_accept),
        .flit_ready (i_flit_ready),
        .flit_valid (o_flit_valid),
        .flit_head  (o_flit_head),
        .flit_tail  (o_flit_tail),
        .flit_data  (o_flit_data)
    );

endmodule

// File: tb/tb_tnoc_flit_injector.sv
// -----------------------------------------------------------------------------
// tb_tnoc_flit_injector
//   Directed bench for tnoc_flit_injector with the default configuration
//   (2 VCs, 4-bit coordinates, 64-bit data, MAX_PAYLOAD 16).
//   Head-flit layout for this configuration:
//     [4:0] length, [5] vc, [9:6] src_x, [13:10] src_y,
//     [17:14] dest_x, [21:18] dest_y.
// -----------------------------------------------------------------------------
module tb_tnoc_flit_injector;
    import tnoc_injector_pkg::*;

    localparam int CH   = 2;
    localparam int IDXW = 4;
    localparam int IDYW = 4;
    localparam int VCW  = 1;
    localparam int LENW = 5;
    localparam int DW   = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [IDXW-1:0] i_id_x;
    logic [IDYW-1:0] i_id_y;
    logic            i_hdr_valid;
    logic            o_hdr_ready;
    logic [VCW-1:0]  i_hdr_vc;
    logic [IDXW-1:0] i_hdr_dest_x;
    logic [IDYW-1:0] i_hdr_dest_y;
    logic [LENW-1:0] i_hdr_length;
    logic            i_pld_valid;
    logic            o_pld_ready;
    logic [DW-1:0]   i_pld_data;
    logic            i_pld_last;
    logic [CH-1:0]   o_flit_valid;
    logic [CH-1:0]   i_flit_ready;
    logic            o_flit_head;
    logic            o_flit_tail;
    logic [DW-1:0]   o_flit_data;
    logic            o_error;

    int n_cmp = 0;
    int n_err = 0;
    int flits = 0;
    int f0;

    tnoc_flit_injector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_id_x       (i_id_x),
        .i_id_y       (i_id_y),
        .i_hdr_valid  (i_hdr_valid),
        .o_hdr_ready  (o_hdr_ready),
        .i_hdr_vc     (i_hdr_vc),
        .i_hdr_dest_x (i_hdr_dest_x),
        .i_hdr_dest_y (i_hdr_dest_y),
        .i_hdr_length (i_hdr_length),
        .i_pld_valid  (i_pld_valid),
        .o_pld_ready  (o_pld_ready),
        .i_pld_data   (i_pld_data),
        .i_pld_last   (i_pld_last),
        .o_flit_valid (o_flit_valid),
        .i_flit_ready (i_flit_ready),
        .o_flit_head  (o_flit_head),
        .o_flit_tail  (o_flit_tail),
        .o_flit_data  (o_flit_data),
        .o_error      (o_error)
    );

    always #5 clk = ~clk;

    // Count every flit handed to the fabric.
    always @(posedge clk) begin
        if (rst_n) flits += $countones(o_flit_valid & i_flit_ready);
    end

    // Valid bits on different VCs must never overlap.
    always @(negedge clk) begin
        n_cmp++;
        assert ($onehot0(o_flit_valid)) else begin
            n_err++;
            $error("FAIL vc_onehot: observed %b expected at most one bit set", o_flit_valid);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] head_word(input int dy, input int dx, input int sy,
                                              input int sx, input int vc, input int len);
        return 64'(len) | (64'(vc) << 5) | (64'(sx) << 6) | (64'(sy) << 10)
             | (64'(dx) << 14) | (64'(dy) << 18);
    endfunction

    // Descriptor to (3,0); source is fixed at (1,2).
    task automatic drive_hdr(input int vc, input int len);
        i_hdr_valid  = 1'b1;
        i_hdr_vc     = VCW'(vc);
        i_hdr_dest_x = 4'd3;
        i_hdr_dest_y = 4'd0;
        i_hdr_length = LENW'(len);
    endtask

    task automatic drive_pld(input logic [63:0] data, input logic last);
        i_pld_valid = 1'b1;
        i_pld_data  = data;
        i_pld_last  = last;
    endtask

    initial begin
        i_id_x = 4'd1;  i_id_y = 4'd2;
        i_hdr_valid = 1'b0; i_hdr_vc = '0; i_hdr_dest_x = '0; i_hdr_dest_y = '0;
        i_hdr_length = '0;
        i_pld_valid = 1'b0; i_pld_data = '0; i_pld_last = 1'b0;
        i_flit_ready = 2'b11;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid",     64'(o_flit_valid), 64'h0);
        check("rst_head",      64'(o_flit_head),  64'h0);
        check("rst_tail",      64'(o_flit_tail),  64'h0);
        check("rst_data",      o_flit_data,       64'h0);
        check("rst_hdr_ready", 64'(o_hdr_ready),  64'h0);
        check("rst_pld_ready", 64'(o_pld_ready),  64'h0);
        check("rst_error",     64'(o_error),      64'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        check("post_rst_hdr_ready", 64'(o_hdr_ready), 64'h1);

        // ---- T1: zero-length packet on vc1 ----
        f0 = flits;
        drive_hdr(1, 0);
        @(negedge clk); i_hdr_valid = 1'b0; #1;
        check("t1_valid", 64'(o_flit_valid), 64'h2);
        check("t1_head",  64'(o_flit_head),  64'h1);
        check("t1_tail",  64'(o_flit_tail),  64'h1);
        check("t1_data",  o_flit_data,       head_word(0, 3, 2, 1, 1, 0));
        check("t1_error", 64'(o_error),      64'h0);
        @(negedge clk); #1;
        check("t1_drained", 64'(o_flit_valid), 64'h0);
        check("t1_count",   64'(flits - f0),   64'd1);

        // ---- T2: length 3, ready always high ----
        f0 = flits;
        drive_hdr(0, 3);
        @(negedge clk); i_hdr_valid = 1'b0; drive_pld(64'hA, 1'b0); #1;
        check("t2_head_valid", 64'(o_flit_valid), 64'h1);
        check("t2_head",       64'(o_flit_head),  64'h1);
        check("t2_head_tail",  64'(o_flit_tail),  64'h0);
        check("t2_head_data",  o_flit_data,       head_word(0, 3, 2, 1, 0, 3));
        check("t2_pld_ready",  64'(o_pld_ready),  64'h1);
        @(negedge clk); drive_pld(64'hB, 1'b0); #1;
        check("t2_a_data", o_flit_data,       64'hA);
        check("t2_a_head", 64'(o_flit_head),  64'h0);
        check("t2_a_tail", 64'(o_flit_tail),  64'h0);
        @(negedge clk); drive_pld(64'hC, 1'b1); #1;
        check("t2_b_data", o_flit_data,       64'hB);
        check("t2_b_tail", 64'(o_flit_tail),  64'h0);
        @(negedge clk); i_pld_valid = 1'b0; i_pld_last = 1'b0; #1;
        check("t2_c_data",    o_flit_data,      64'hC);
        check("t2_c_tail",    64'(o_flit_tail), 64'h1);
        check("t2_hdr_ready", 64'(o_hdr_ready), 64'h1);
        @(negedge clk); #1;
        check("t2_drained", 64'(o_flit_valid), 64'h0);
        check("t2_count",   64'(flits - f0),   64'd4);

        // ---- T3: same packet, head backpressured 5 cycles ----
        f0 = flits;
        drive_hdr(0, 3);
        @(negedge clk); i_hdr_valid = 1'b0; i_flit_ready = 2'b00; drive_pld(64'hA, 1'b0); #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk); #1;
            end
            check("t3_hold_valid", 64'(o_flit_valid), 64'h1);
            check("t3_hold_head",  64'(o_flit_head),  64'h1);
            check("t3_hold_data",  o_flit_data,       head_word(0, 3, 2, 1, 0, 3));
            check("t3_pld_ready",  64'(o_pld_ready),  64'h0);
        end
        @(negedge clk); i_flit_ready = 2'b11; #1;
        check("t3_release_ready", 64'(o_pld_ready), 64'h1);
        @(negedge clk); drive_pld(64'hB, 1'b0); #1;
        check("t3_a_data", o_flit_data, 64'hA);
        @(negedge clk); drive_pld(64'hC, 1'b1); #1;
        check("t3_b_data", o_flit_data, 64'hB);
        @(negedge clk); i_pld_valid = 1'b0; i_pld_last = 1'b0; #1;
        check("t3_c_data", o_flit_data,      64'hC);
        check("t3_c_tail", 64'(o_flit_tail), 64'h1);
        @(negedge clk); #1;
        check("t3_count", 64'(flits - f0), 64'd4);

        // ---- T4: length 2 with early last ----
        f0 = flits;
        drive_hdr(1, 2);
        @(negedge clk); i_hdr_valid = 1'b0; drive_pld(64'h1111, 1'b1); #1;
        check("t4_head_data", o_flit_data,  head_word(0, 3, 2, 1, 1, 2));
        check("t4_error_pre", 64'(o_error), 64'h0);
        @(negedge clk); drive_pld(64'h2222, 1'b0); #1;
        check("t4_b1_data",  o_flit_data,       64'h1111);
        check("t4_b1_valid", 64'(o_flit_valid), 64'h2);
        check("t4_b1_tail",  64'(o_flit_tail),  64'h0);
        check("t4_error",    64'(o_error),      64'h1);
        @(negedge clk); i_pld_valid = 1'b0; #1;
        check("t4_b2_data", o_flit_data,      64'h2222);
        check("t4_b2_tail", 64'(o_flit_tail), 64'h1);
        @(negedge clk); #1;
        check("t4_error_sticky", 64'(o_error),    64'h1);
        check("t4_count",        64'(flits - f0), 64'd3);

        // ---- T5: back-to-back vc0 then vc1 ----
        f0 = flits;
        drive_hdr(0, 1);
        @(negedge clk); i_hdr_valid = 1'b0; drive_pld(64'h3333, 1'b1); #1;
        check("t5_h0_data", o_flit_data, head_word(0, 3, 2, 1, 0, 1));
        @(negedge clk); i_pld_valid = 1'b0; i_pld_last = 1'b0; drive_hdr(1, 0); #1;
        check("t5_tail0_valid", 64'(o_flit_valid), 64'h1);
        check("t5_tail0_data",  o_flit_data,       64'h3333);
        check("t5_tail0_tail",  64'(o_flit_tail),  64'h1);
        check("t5_hdr_ready",   64'(o_hdr_ready),  64'h1);
        @(negedge clk); i_hdr_valid = 1'b0; #1;
        check("t5_h1_valid", 64'(o_flit_valid), 64'h2);
        check("t5_h1_head",  64'(o_flit_head),  64'h1);
        check("t5_h1_data",  o_flit_data,       head_word(0, 3, 2, 1, 1, 0));
        @(negedge clk); #1;
        check("t5_count", 64'(flits - f0), 64'd3);

        // ---- T6: reset pulsed mid-payload ----
        drive_hdr(0, 3);
        @(negedge clk); i_hdr_valid = 1'b0; drive_pld(64'hA, 1'b0);
        @(negedge clk); drive_pld(64'hB, 1'b0); #1;
        check("t6_a_data", o_flit_data, 64'hA);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid",     64'(o_flit_valid), 64'h0);
        check("t6_rst_head",      64'(o_flit_head),  64'h0);
        check("t6_rst_data",      o_flit_data,       64'h0);
        check("t6_rst_hdr_ready", 64'(o_hdr_ready),  64'h0);
        check("t6_rst_pld_ready", 64'(o_pld_ready),  64'h0);
        check("t6_rst_error",     64'(o_error),      64'h0);
        i_pld_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); drive_hdr(1, 0); #1;
        check("t6_hdr_ready", 64'(o_hdr_ready), 64'h1);
        @(negedge clk); i_hdr_valid = 1'b0; #1;
        check("t6_new_valid", 64'(o_flit_valid), 64'h2);
        check("t6_new_data",  o_flit_data,       head_word(0, 3, 2, 1, 1, 0));
        check("t6_new_tail",  64'(o_flit_tail),  64'h1);
        check("t6_new_error", 64'(o_error),      64'h0);

        // ---- T7: length 20 clamped to 16 ----
        @(negedge clk);
        f0 = flits;
        drive_hdr(0, 20);
        @(negedge clk); i_hdr_valid = 1'b0; #1;
        check("t7_head_data", o_flit_data,  head_word(0, 3, 2, 1, 0, 16));
        check("t7_error",     64'(o_error), 64'h1);
        for (int k = 0; k < 16; k++) begin
            drive_pld(64'h100 + 64'(k), (k == 15));
            @(negedge clk); #1;
            check("t7_beat_data", o_flit_data,      64'h100 + 64'(k));
            check("t7_beat_tail", 64'(o_flit_tail), (k == 15) ? 64'h1 : 64'h0);
        end
        i_pld_valid = 1'b0; i_pld_last = 1'b0;
        @(negedge clk); #1;
        check("t7_drained", 64'(o_flit_valid), 64'h0);
        check("t7_count",   64'(flits - f0),   64'd17);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
